muldiv_unit: RTL

- Iterative RV32M multiply/divide execution unit.
- Consumes rs1_data/rs2_data read from the register file and produces rd_data, rd_address and write_enable for the register file write port.
- Multi-cycle: one radix-2 step per clock; the core stalls on busy.

---
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Performs one radix-2 step per clock on operand magnitudes. The result sign
// is applied when entering DONE, and the result is presented for one cycle
// on the register-file write port. Divide-by-zero and signed overflow results
// are precomputed when the operands are latched.
module muldiv_unit #(
    parameter int FAST_SPECIAL = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_address_in,
    input  logic        flush,
    output logic        busy,
    output logic        write_enable,
    output logic [4:0]  rd_address,
    output logic [31:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] hi_q, hi_d;       // product high half / partial remainder
    logic [31:0] lo_q, lo_d;       // multiplier bits / dividend-quotient
    logic [31:0] b_q, b_d;         // multiplicand or divisor magnitude
    logic        neg_q, neg_d;
    logic        special_q, special_d;
    logic [31:0] spec_q, spec_d;
    logic [31:0] res_q, res_d;

    // Conditional two's complement negation used for magnitudes and results.
    function automatic logic [63:0] cond_neg(input logic [63:0] v, input logic n);
        return n ? (64'd0 - v) : v;
    endfunction

    // Operand decode: signedness, magnitudes, result sign and special results.
    logic        is_div_in, a_signed_in, b_signed_in, a_neg_in, b_neg_in, neg_in;
    logic        div_zero_in, div_ovf_in;
    logic [31:0] a_mag_in, b_mag_in, spec_res_in;
    logic [63:0] a_mag_w, b_mag_w;

    // Decode the incoming operation before it is latched in IDLE.
    always_comb begin
        is_div_in = funct3[2];
        if (is_div_in) begin
            a_signed_in = ~funct3[0];
            b_signed_in = ~funct3[0];
        end else begin
            a_signed_in = funct3[1] ^ funct3[0];
            b_signed_in = (funct3[1:0] == 2'b01);
        end
        a_neg_in = a_signed_in & rs1_data[31];
        b_neg_in = b_signed_in & rs2_data[31];
        a_mag_w  = cond_neg({32'd0, rs1_data}, a_neg_in);
        b_mag_w  = cond_neg({32'd0, rs2_data}, b_neg_in);
        a_mag_in = a_mag_w[31:0];
        b_mag_in = b_mag_w[31:0];
        // Remainder takes the dividend sign; everything else the XOR.
        if (is_div_in && funct3[1]) neg_in = a_neg_in;
        else                        neg_in = a_neg_in ^ b_neg_in;
        div_zero_in = is_div_in && (rs2_data == 32'd0);
        div_ovf_in  = is_div_in && !funct3[0] && (rs1_data == 32'h8000_0000)
                      && (rs2_data == 32'hFFFF_FFFF);
        spec_res_in = 32'd0;
        if (div_zero_in)     spec_res_in = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
        else if (div_ovf_in) spec_res_in = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // Iteration step and final sign correction.
    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic [31:0] div_sub;
    logic        div_ge;
    logic [63:0] prod_fix, div_fix;
    logic [31:0] mul_res, div_res;

    // One shift-add / restoring-divide step plus the signed final results.
    always_comb begin
        mul_sum  = lo_q[0] ? ({1'b0, hi_q} + {1'b0, b_q}) : {1'b0, hi_q};
        div_sh   = {hi_q, lo_q[31]};
        div_sub  = div_sh[31:0] - b_q;
        div_ge   = (div_sh >= {1'b0, b_q});
        prod_fix = cond_neg({hi_q, lo_q}, neg_q);
        mul_res  = (op_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
        div_fix  = cond_neg({32'd0, (op_q[1] ? hi_q : lo_q)}, neg_q);
        div_res  = div_fix[31:0];
    end

    // Next-state and datapath update for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        neg_d     = neg_q;
        special_d = special_q;
        spec_d    = spec_q;
        res_d     = res_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    state_d   = CALC;
                    cnt_d     = 6'd0;
                    op_d      = funct3;
                    rd_d      = rd_address_in;
                    hi_d      = 32'd0;
                    lo_d      = is_div_in ? a_mag_in : b_mag_in;
                    b_d       = is_div_in ? b_mag_in : a_mag_in;
                    neg_d     = neg_in;
                    special_d = div_zero_in | div_ovf_in;
                    spec_d    = spec_res_in;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (special_q && (FAST_SPECIAL != 0)) begin
                    state_d = DONE;
                    res_d   = spec_q;
                end else if (cnt_q == 6'd32) begin
                    state_d = DONE;
                    if (special_q)    res_d = spec_q;
                    else if (op_q[2]) res_d = div_res;
                    else              res_d = mul_res;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    if (op_q[2]) begin
                        hi_d = div_ge ? div_sub : div_sh[31:0];
                        lo_d = {lo_q[30:0], div_ge};
                    end else begin
                        hi_d = mul_sum[32:1];
                        lo_d = {mul_sum[0], lo_q[31:1]};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            op_q      <= 3'd0;
            rd_q      <= 5'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            b_q       <= 32'd0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            spec_q    <= 32'd0;
            res_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            spec_q    <= spec_d;
            res_q     <= res_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign write_enable = (state_q == DONE) && !flush;
    assign rd_address   = rd_q;
    assign rd_data      = res_q;

endmodule
